bitstream_packer: RTL and testbench

BITSTREAM_PACKER -- requirements
Module: bitstream_packer

---
 rtl/bitstream_packer.sv | 150 +++++++++++++++
 tb/tb_bitstream_packer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_packer.sv
// Variable-length code packer: appends right-aligned codes MSB-first and writes 32-bit words to a RAM.
// Optional macro BITPACK_PAD_ONES_EN: the final partial word is padded with 1s instead of 0s.
module bitstream_packer #(
    parameter int WORDS = 2406,
    parameter int AW    = 13
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          valid_i,
    input  logic [15:0]   code_i,
    input  logic [4:0]    len_i,
    input  logic          flush_i,
    output logic          ready_o,
    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [31:0]   ram_data_o,
    output logic [AW:0]   word_count_o,
    output logic          done_o,
    output logic          ovf_o
);

`ifdef BITPACK_PAD_ONES_EN
    localparam logic PAD_ONES = 1'b1;
`else
    localparam logic PAD_ONES = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ACCUM, WRITE, FLUSH, DONE} state_t;

    state_t      state, state_nx;
    logic [47:0] acc, acc_nx;
    logic [5:0]  bitcnt, bitcnt_nx;
    logic [AW:0] ptr, ptr_nx;
    logic        ovf, ovf_nx;

    logic        ready, wr;
    logic [31:0] wdata;
    logic [4:0]  len_eff;
    logic [16:0] code_m;
    logic [5:0]  sh;
    logic [31:0] pad_mask;
    logic        full;

    // Oldest bit lives at acc[47]; a new code is placed just below the bits already held.
    always_comb begin
        len_eff  = (len_i > 5'd16) ? 5'd16 : len_i;
        code_m   = {1'b0, code_i} & ((17'd1 << len_eff) - 17'd1);
        sh       = 6'd48 - bitcnt - {1'b0, len_eff};
        pad_mask = 32'hFFFF_FFFF >> bitcnt;
        full     = (int'(ptr) >= WORDS);
    end

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        bitcnt_nx = bitcnt;
        ptr_nx    = ptr;
        ovf_nx    = ovf;
        ready     = 1'b0;
        wr        = 1'b0;
        wdata     = acc[47:16];
        case (state)
            IDLE: begin
                if (en_i) begin
                    state_nx  = ACCUM;
                    acc_nx    = '0;
                    bitcnt_nx = '0;
                    ptr_nx    = '0;
                end
            end
            ACCUM: begin
                if (en_i && (bitcnt < 6'd32)) begin
                    ready = 1'b1;
                    if (valid_i) begin
                        acc_nx    = acc | ({31'b0, code_m} << sh);
                        bitcnt_nx = bitcnt + {1'b0, len_eff};
                        if (bitcnt_nx >= 6'd32)
                            state_nx = WRITE;
                    end else if (flush_i) begin
                        state_nx = FLUSH;
                    end
                end
            end
            WRITE: begin
                if (en_i) begin
                    if (full) begin
                        ovf_nx   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        wr        = 1'b1;
                        ptr_nx    = ptr + 1'b1;
                        acc_nx    = acc << 32;
                        bitcnt_nx = bitcnt - 6'd32;
                        state_nx  = ACCUM;
                    end
                end
            end
            FLUSH: begin
                wdata = acc[47:16] | (PAD_ONES ? pad_mask : 32'h0);
                if (en_i) begin
                    if (bitcnt != 6'd0) begin
                        if (full) begin
                            ovf_nx = 1'b1;
                        end else begin
                            wr     = 1'b1;
                            ptr_nx = ptr + 1'b1;
                        end
                    end
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (!en_i)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            acc    <= '0;
            bitcnt <= '0;
            ptr    <= '0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nx;
            acc    <= acc_nx;
            bitcnt <= bitcnt_nx;
            ptr    <= ptr_nx;
            ovf    <= ovf_nx;
        end
    end

    // Outputs are forced quiet while reset is asserted, not just after the reset edge.
    always_comb begin
        ready_o      = rst_i & ready;
        ram_en_o     = rst_i & wr;
        ram_we_o     = rst_i & wr;
        ram_addr_o   = rst_i ? ptr[AW-1:0] : '0;
        ram_data_o   = rst_i ? wdata : '0;
        word_count_o = rst_i ? ptr : '0;
        done_o       = rst_i && (state == DONE);
        ovf_o        = rst_i & ovf;
    end

endmodule

// File: tb/tb_bitstream_packer.sv
// Self-checking bench for bitstream_packer: bit-queue reference model with a write scoreboard,
// a vector table, and directed sequences for flush, reset, freeze and overflow.
module tb_bitstream_packer;

`ifdef BITPACK_PAD_ONES_EN
    localparam logic        PADBIT   = 1'b1;
    localparam logic [31:0] PAD_WORD = 32'hBFFF_FFFF;
`else
    localparam logic        PADBIT   = 1'b0;
    localparam logic [31:0] PAD_WORD = 32'hA000_0000;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, valid, flush;
    logic [15:0] code;
    logic [4:0]  len;
    logic        ready, ram_en, ram_we, done, ovf;
    logic [12:0] ram_addr;
    logic [31:0] ram_data;
    logic [13:0] wc;

    logic        s_en, s_valid, s_flush;
    logic [15:0] s_code;
    logic [4:0]  s_len;
    logic        s_ready, s_ram_en, s_ram_we, s_done, s_ovf;
    logic [12:0] s_addr;
    logic [31:0] s_data;
    logic [13:0] s_wc;

    bitstream_packer #(.WORDS(2406), .AW(13)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .valid_i(valid), .code_i(code), .len_i(len),
        .flush_i(flush), .ready_o(ready), .ram_en_o(ram_en), .ram_we_o(ram_we),
        .ram_addr_o(ram_addr), .ram_data_o(ram_data), .word_count_o(wc),
        .done_o(done), .ovf_o(ovf)
    );

    bitstream_packer #(.WORDS(2), .AW(13)) dut_small (
        .clk_i(clk), .rst_i(rst), .en_i(s_en), .valid_i(s_valid), .code_i(s_code), .len_i(s_len),
        .flush_i(s_flush), .ready_o(s_ready), .ram_en_o(s_ram_en), .ram_we_o(s_ram_we),
        .ram_addr_o(s_addr), .ram_data_o(s_data), .word_count_o(s_wc),
        .done_o(s_done), .ovf_o(s_ovf)
    );

    // Write monitors: each is the only writer of its own log.
    logic [12:0] obs_addr [256];
    logic [31:0] obs_data [256];
    int obs_cnt = 0;
    logic [12:0] s_obs_addr [16];
    logic [31:0] s_obs_data [16];
    int s_obs_cnt = 0;
    int strobe_split = 0;

    always @(negedge clk) begin
        if (ram_en !== ram_we || s_ram_en !== s_ram_we) strobe_split++;
        if (ram_we === 1'b1 && obs_cnt < 256) begin
            obs_addr[obs_cnt] = ram_addr;
            obs_data[obs_cnt] = ram_data;
            obs_cnt++;
        end
        if (s_ram_we === 1'b1 && s_obs_cnt < 16) begin
            s_obs_addr[s_obs_cnt] = s_addr;
            s_obs_data[s_obs_cnt] = s_data;
            s_obs_cnt++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Reference model: a plain bit queue, oldest bit at the front.
    typedef struct { logic [12:0] addr; logic [31:0] data; } wr_t;
    wr_t exp_q[$];
    bit  mq[$];
    int  mptr = 0;
    int  rd_idx = 0;

    task automatic model_push(input logic [15:0] c, input logic [4:0] l);
        int n;
        logic [31:0] w;
        n = (l > 5'd16) ? 16 : int'(l);
        for (int i = n - 1; i >= 0; i--) mq.push_back(c[i]);
        while (mq.size() >= 32) begin
            w = '0;
            for (int k = 0; k < 32; k++) w = {w[30:0], mq.pop_front()};
            exp_q.push_back('{13'(mptr), w});
            mptr++;
        end
    endtask

    task automatic model_flush();
        logic [31:0] w;
        if (mq.size() > 0) begin
            while (mq.size() < 32) mq.push_back(PADBIT);
            w = '0;
            for (int k = 0; k < 32; k++) w = {w[30:0], mq.pop_front()};
            exp_q.push_back('{13'(mptr), w});
            mptr++;
        end
    endtask

    task automatic drain(input string name);
        wr_t e;
        while (rd_idx < obs_cnt) begin
            if (exp_q.size() == 0) begin
                fail_now({name, "_extra_write"});
            end else begin
                e = exp_q.pop_front();
                check({name, "_addr"}, 64'(obs_addr[rd_idx]), 64'(e.addr));
                check({name, "_data"}, 64'(obs_data[rd_idx]), 64'(e.data));
            end
            rd_idx++;
        end
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic send(input logic [15:0] c, input logic [4:0] l);
        int n;
        valid = 1'b1; code = c; len = l;
        #1;
        n = 0;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        if (!ready) begin
            fail_now("send_ready_timeout");
            valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_push(c, l);
        #1 valid = 1'b0;
    endtask

    task automatic do_flush(input string name);
        int n;
        valid = 1'b0; flush = 1'b1;
        #1;
        n = 0;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        if (!ready) begin
            fail_now({name, "_flush_ready_timeout"});
            flush = 1'b0;
            return;
        end
        @(posedge clk);
        model_flush();
        #1 flush = 1'b0;
        n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        check({name, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic start();
        en = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
        mptr = 0;
    endtask

    task automatic stop();
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [15:0] code; logic [4:0] len; } vec_t;
    vec_t vt [12];

    initial begin
        int base, n, ready_hi;

        vt[0]  = '{16'h1234, 5'd16};
        vt[1]  = '{16'hFFFF, 5'd3};
        vt[2]  = '{16'h0000, 5'd0};
        vt[3]  = '{16'h00AB, 5'd8};
        vt[4]  = '{16'hFFFF, 5'd20};
        vt[5]  = '{16'h8001, 5'd16};
        vt[6]  = '{16'h0001, 5'd1};
        vt[7]  = '{16'h7FFF, 5'd15};
        vt[8]  = '{16'hA5A5, 5'd31};
        vt[9]  = '{16'h0003, 5'd2};
        vt[10] = '{16'h0F0F, 5'd12};
        vt[11] = '{16'hFFFF, 5'd7};

        rst = 1'b0; en = 1'b0; valid = 1'b0; flush = 1'b0; code = '0; len = '0;
        s_en = 1'b0; s_valid = 1'b0; s_flush = 1'b0; s_code = '0; s_len = '0;

        // Reset state
        repeat (2) @(posedge clk);
        en = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_ram_en", 64'(ram_en), 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_addr", 64'(ram_addr), 64'd0);
        check("rst_data", 64'(ram_data), 64'd0);
        check("rst_wc", 64'(wc), 64'd0);
        check("rst_small_ovf", 64'(s_ovf), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1; en = 1'b0;
        @(posedge clk);
        #1;

        // Eight 4-bit codes make exactly one word; empty flush writes nothing
        start();
        base = obs_cnt;
        for (int i = 0; i < 8; i++) send(16'h000A, 5'd4);
        repeat (2) @(negedge clk);
        check("w8_count", 64'(obs_cnt - base), 64'd1);
        check("w8_addr", 64'(obs_addr[base]), 64'd0);
        check("w8_data", 64'(obs_data[base]), 64'hAAAA_AAAA);
        do_flush("w8");
        check("w8_count_after_flush", 64'(obs_cnt - base), 64'd1);
        check("w8_wc", 64'(wc), 64'd1);
        drain("w8");
        stop();
        check("idle_after_done", 64'(done), 64'd0);

        // Partial final word gets padded
        start();
        base = obs_cnt;
        send(16'hABCD, 5'd16);
        send(16'h1234, 5'd16);
        send(16'h0005, 5'd3);
        do_flush("pad");
        check("pad_count", 64'(obs_cnt - base), 64'd2);
        check("pad_w0", 64'(obs_data[base]), 64'hABCD_1234);
        check("pad_a1", 64'(obs_addr[base + 1]), 64'd1);
        check("pad_w1", 64'(obs_data[base + 1]), 64'(PAD_WORD));
        check("pad_wc", 64'(wc), 64'd2);
        drain("pad");
        stop();

        // Masked high bits, zero length, over-long length clamped to 16
        start();
        base = obs_cnt;
        send(16'hFFFF, 5'd4);
        send(16'h0000, 5'd0);
        send(16'h0000, 5'd28);
        repeat (2) @(negedge clk);
        check("clamp_no_write_at_20", 64'(obs_cnt - base), 64'd0);
        send(16'h0000, 5'd12);
        check("write_cycle_ready_low", 64'(ready), 64'd0);
        check("write_cycle_strobe", 64'(ram_we), 64'd1);
        repeat (2) @(negedge clk);
        check("clamp_data", 64'(obs_data[base]), 64'hF000_0000);
        do_flush("clamp");
        check("clamp_count", 64'(obs_cnt - base), 64'd1);
        drain("clamp");
        stop();

        // Reset mid-word discards the partial word
        start();
        base = obs_cnt;
        send(16'hFFFF, 5'd16);
        send(16'h000F, 5'd4);
        rst = 1'b0; en = 1'b0;
        @(negedge clk);
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_we", 64'(ram_we), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        mq.delete();
        start();
        send(16'h1234, 5'd16);
        send(16'h5678, 5'd16);
        repeat (2) @(negedge clk);
        check("midrst_count", 64'(obs_cnt - base), 64'd1);
        check("midrst_addr", 64'(obs_addr[base]), 64'd0);
        check("midrst_data", 64'(obs_data[base]), 64'h1234_5678);
        do_flush("midrst");
        drain("midrst");
        stop();

        // Enable dropped during WRITE freezes the pending write
        start();
        base = obs_cnt;
        send(16'hDEAD, 5'd16);
        send(16'hBEEF, 5'd16);
        en = 1'b0;
        ready_hi = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready) ready_hi++;
        end
        check("freeze_ready_low", 64'(ready_hi), 64'd0);
        @(posedge clk);
        #1 en = 1'b1;
        repeat (2) @(negedge clk);
        check("freeze_single_write", 64'(obs_cnt - base), 64'd1);
        check("freeze_data", 64'(obs_data[base]), 64'hDEAD_BEEF);
        send(16'hC0DE, 5'd16);
        do_flush("freeze");
        drain("freeze");
        stop();

        // Vector table then a random stream through the scoreboard
        start();
        for (int i = 0; i < 12; i++) send(vt[i].code, vt[i].len);
        do_flush("table");
        check("table_wc", 64'(wc), 64'd4);
        drain("table");
        stop();
        start();
        for (int i = 0; i < 60; i++) send(16'($urandom), 5'($urandom_range(0, 31)));
        do_flush("random");
        drain("random");
        stop();

        // Overflow on a two-word RAM
        s_en = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1; s_code = 16'h00FF; s_len = 5'd8;
            #1;
            n = 0;
            while (!s_ready && !s_done && n < 20) begin @(negedge clk); n++; end
            if (s_done) break;
            if (!s_ready) begin
                fail_now("ovf_ready_timeout");
                break;
            end
            @(posedge clk);
            #1 s_valid = 1'b0;
        end
        s_valid = 1'b0;
        n = 0;
        while (!s_done && n < 20) begin @(negedge clk); n++; end
        check("ovf_done", 64'(s_done), 64'd1);
        check("ovf_flag", 64'(s_ovf), 64'd1);
        check("ovf_wc", 64'(s_wc), 64'd2);
        check("ovf_writes", 64'(s_obs_cnt), 64'd2);
        check("ovf_a0", 64'(s_obs_addr[0]), 64'd0);
        check("ovf_a1", 64'(s_obs_addr[1]), 64'd1);
        check("ovf_d1", 64'(s_obs_data[1]), 64'hFFFF_FFFF);
        s_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ovf_sticky", 64'(s_ovf), 64'd1);

        check("strobe_pair", 64'(strobe_split), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
